phys_reg_alloc_ctrl: RTL

- Owns the physical-register free list and the branch checkpoint stack for the rename stage.
- Arbitrates rename-time allocation against commit-time reclaim.
- Checkpoints free-list head on each decoded branch; restores it on mispredict.
- After reset, sequences free-list initialisation with tags NUM_ARCH_REGS..NUM_PHYS_REGS-1; sits between decode/rename and the commit/branch-resolve logic.

---
 rtl/mips_core_pkg.sv | 20 ++
 rtl/alloc_ckpt_stack.sv | 63 ++++++
 rtl/phys_reg_alloc_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// Shared types for the rename-stage physical register allocator.
// Default geometry, tag/checkpoint types and allocator FSM states.
package mips_core_pkg;

    localparam int DEF_NUM_ARCH_REGS = 32;
    localparam int DEF_NUM_PHYS_REGS = 64;
    localparam int DEF_NUM_CKPT      = 4;
    localparam int DEF_TAG_W         = $clog2(DEF_NUM_PHYS_REGS);
    localparam int DEF_CKPT_W        = $clog2(DEF_NUM_CKPT);

    typedef logic [DEF_TAG_W-1:0]  PhysReg;
    typedef logic [DEF_CKPT_W-1:0] CkptId;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } AllocState;

endpackage

// File: rtl/alloc_ckpt_stack.sv
// Circular store of saved free-list head pointers, one per live branch.
// Oldest branch at rd_ptr; a mispredict truncates back to its own slot.
module alloc_ckpt_stack
    import mips_core_pkg::*;
#(
    parameter int NUM_CKPT = DEF_NUM_CKPT,
    parameter int PTR_W    = 6,
    parameter int CK_W     = $clog2(NUM_CKPT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [PTR_W-1:0] push_head,
    input  logic            pop,
    input  logic            trunc,
    input  logic [CK_W-1:0] trunc_id,
    input  logic [CK_W-1:0] query_id,
    output logic            query_live,
    output logic [PTR_W-1:0] query_head,
    output logic [CK_W-1:0] rd_ptr,
    output logic [CK_W-1:0] wr_ptr,
    output logic [CK_W:0]   count,
    output logic            full
);

    logic [PTR_W-1:0] slot_q [NUM_CKPT];
    logic [CK_W-1:0]  rd_q;
    logic [CK_W-1:0]  wr_q;
    logic [CK_W:0]    cnt_q;
    logic [CK_W-1:0]  q_off;
    logic [CK_W-1:0]  t_off;

    assign q_off      = query_id - rd_q;
    assign t_off      = trunc_id - rd_q;
    assign query_live = {1'b0, q_off} < cnt_q;
    assign query_head = slot_q[query_id];
    assign rd_ptr     = rd_q;
    assign wr_ptr     = wr_q;
    assign count      = cnt_q;
    assign full       = cnt_q == (CK_W+1)'(NUM_CKPT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (trunc) begin
            // the mispredicted branch's own slot is discarded too
            wr_q  <= trunc_id;
            cnt_q <= {1'b0, t_off};
            if (pop) rd_q <= rd_q + 1'b1;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (CK_W+1)'(push) - (CK_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) slot_q[wr_q] <= push_head;
    end

endmodule

// File: rtl/phys_reg_alloc_ctrl.sv
// Rename-stage free list of physical tags with branch checkpoint/rollback.
// Rollback only moves head: squashed tags are still in their slots.
module phys_reg_alloc_ctrl
    import mips_core_pkg::*;
#(
    parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
    parameter int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
    parameter int NUM_CKPT      = DEF_NUM_CKPT,
    parameter int TAG_W         = $clog2(NUM_PHYS_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc_req,
    output logic                       alloc_gnt,
    output logic [TAG_W-1:0]           alloc_tag,
    input  logic                       free_req,
    input  logic [TAG_W-1:0]           free_tag,
    output logic                       free_ack,
    input  logic                       ckpt_req,
    output logic                       ckpt_gnt,
    output logic [$clog2(NUM_CKPT)-1:0] ckpt_id,
    input  logic                       resolve_valid,
    input  logic [$clog2(NUM_CKPT)-1:0] resolve_id,
    input  logic                       resolve_mispredict,
    output logic                       ready,
    output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0] free_count,
    output logic                       ckpt_full,
    output logic                       err
);

    localparam int FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int IDX_W    = $clog2(FL_DEPTH);
    localparam int PTR_W    = IDX_W + 1;
    localparam int CK_W     = $clog2(NUM_CKPT);

    AllocState        state_q;
    AllocState        state_d;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W-1:0] init_ctr_q;
    logic             err_q;
    logic [TAG_W-1:0] fl_ram [FL_DEPTH];

    logic             active;
    logic             fl_full;
    logic             mispredict_now;
    logic             res_ok;
    logic             res_bad;
    logic             mp_ok;
    logic             mp_bad;
    logic             free_bad;
    logic             fl_we;
    logic [TAG_W-1:0] fl_wdata;

    logic [CK_W-1:0]  ck_rd_ptr;
    logic [CK_W-1:0]  ck_wr_ptr;
    logic [CK_W:0]    ck_count;
    logic             ck_live;
    logic [PTR_W-1:0] ck_head;
    logic [PTR_W-1:0] push_head;

    assign free_count     = tail_q - head_q;
    assign fl_full        = free_count == PTR_W'(FL_DEPTH);
    assign active         = (state_q == RUN) || (state_q == RECOVER);
    assign mispredict_now = resolve_valid && resolve_mispredict;

    // a correct resolve must retire the oldest live checkpoint
    assign res_ok   = active && resolve_valid && !resolve_mispredict
                   && resolve_id == ck_rd_ptr && ck_count != '0;
    assign res_bad  = active && resolve_valid && !resolve_mispredict && !res_ok;
    assign mp_ok    = active && mispredict_now && ck_live;
    assign mp_bad   = active && mispredict_now && !ck_live;
    assign free_bad = active && free_req && fl_full;

    assign push_head = head_q + PTR_W'(alloc_gnt);
    assign ckpt_id   = ck_wr_ptr;
    assign alloc_tag = fl_ram[head_q[IDX_W-1:0]];
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (init_ctr_q == PTR_W'(FL_DEPTH - 1)) state_d = RUN;
            RUN:     if (mp_ok) state_d = RECOVER;
            RECOVER: state_d = mp_ok ? RECOVER : RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        alloc_gnt = 1'b0;
        free_ack  = 1'b0;
        ckpt_gnt  = 1'b0;
        unique case (state_q)
            RUN: begin
                ready     = 1'b1;
                alloc_gnt = alloc_req && free_count != '0 && !mispredict_now;
                free_ack  = free_req && !fl_full;
                ckpt_gnt  = ckpt_req && !ckpt_full && !mispredict_now;
            end
            RECOVER: free_ack = free_req && !fl_full;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            init_ctr_q <= '0;
            err_q      <= 1'b0;
        end else if (state_q == INIT) begin
            tail_q     <= tail_q + 1'b1;
            init_ctr_q <= init_ctr_q + 1'b1;
        end else begin
            if (free_ack)  tail_q <= tail_q + 1'b1;
            if (mp_ok)     head_q <= ck_head;
            else if (alloc_gnt) head_q <= head_q + 1'b1;
            if (free_bad || res_bad || mp_bad) err_q <= 1'b1;
        end
    end

    assign fl_we    = (state_q == INIT) || free_ack;
    assign fl_wdata = (state_q == INIT)
                    ? TAG_W'(NUM_ARCH_REGS) + TAG_W'(init_ctr_q)
                    : free_tag;

    always_ff @(posedge clk) begin
        if (fl_we) fl_ram[tail_q[IDX_W-1:0]] <= fl_wdata;
    end

    alloc_ckpt_stack #(
        .NUM_CKPT (NUM_CKPT),
        .PTR_W    (PTR_W),
        .CK_W     (CK_W)
    ) u_ckpt (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ckpt_gnt),
        .push_head  (push_head),
        .pop        (res_ok),
        .trunc      (mp_ok),
        .trunc_id   (resolve_id),
        .query_id   (resolve_id),
        .query_live (ck_live),
        .query_head (ck_head),
        .rd_ptr     (ck_rd_ptr),
        .wr_ptr     (ck_wr_ptr),
        .count      (ck_count),
        .full       (ckpt_full)
    );

endmodule
